// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - programmable down-counting timer with prescaler, one-shot/auto-reload, Done strobe and sticky Irq
module countdown_timer #(
    parameter int WIDTH    = 64,
    parameter int PRESCALE = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Mode,
    input  logic             En,
    input  logic             IrqClr,
    output logic [WIDTH-1:0] Count,
    output logic             Busy,
    output logic             Done,
    output logic             Irq
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COUNT  = 2'd2,
        S_EXPIRE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] preset_q, preset_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             irq_q, irq_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            preset_q <= '0;
            count_q  <= '0;
            pre_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pre_q    <= pre_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        preset_d = preset_q;
        count_d  = count_q;
        pre_d    = pre_q;
        irq_d    = irq_q;

        if (Stop) begin
            // Abort keeps Count and Irq, but an expiry in progress still raises Irq
            state_d = S_IDLE;
            pre_d   = '0;
            if (state_q == S_EXPIRE) begin
                irq_d = 1'b1;
            end
        end else begin
            if (Load) begin
                preset_d = LoadVal;
            end
            if (IrqClr) begin
                irq_d = 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    count_d = preset_q;
                    pre_d   = '0;
                    state_d = (preset_q != '0) ? S_COUNT : S_EXPIRE;
                end
                S_COUNT: begin
                    if (En) begin
                        if (pre_q == PRE_LAST) begin
                            pre_d = '0;
                            if (count_q != '0) begin
                                count_d = count_q - WIDTH'(1);
                            end
                            if (count_q <= WIDTH'(1)) begin
                                state_d = S_EXPIRE;
                            end
                        end else begin
                            pre_d = pre_q + PW'(1);
                        end
                    end
                end
                S_EXPIRE: begin
                    // Expiry set beats a simultaneous IrqClr
                    irq_d   = 1'b1;
                    state_d = Mode ? S_LOAD : S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign Count = count_q;
    assign Busy  = (state_q != S_IDLE);
    assign Done  = (state_q == S_EXPIRE);
    assign Irq   = irq_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed self-checking bench for countdown_timer
module tb_countdown_timer;

    localparam int W = 64;
    localparam int P = 4;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Load;
    logic [W-1:0] LoadVal;
    logic         Start;
    logic         Stop;
    logic         Mode;
    logic         En;
    logic         IrqClr;
    logic [W-1:0] Count;
    logic         Busy;
    logic         Done;
    logic         Irq;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    countdown_timer #(.WIDTH(W), .PRESCALE(P)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Load    (Load),
        .LoadVal (LoadVal),
        .Start   (Start),
        .Stop    (Stop),
        .Mode    (Mode),
        .En      (En),
        .IrqClr  (IrqClr),
        .Count   (Count),
        .Busy    (Busy),
        .Done    (Done),
        .Irq     (Irq)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_preset(input logic [W-1:0] v);
        Load    = 1'b1;
        LoadVal = v;
        tick();
        Load    = 1'b0;
    endtask

    // The Start pulse is sampled at what the tests call edge 0
    task automatic start_pulse();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_count"}, Count, W'(0));
        check({tag, "_busy"},  W'(Busy), W'(0));
        check({tag, "_done"},  W'(Done), W'(0));
        check({tag, "_irq"},   W'(Irq),  W'(0));
    endtask

    initial begin
        Reset = 1'b1; Load = 1'b0; LoadVal = '0; Start = 1'b0; Stop = 1'b0;
        Mode = 1'b0; En = 1'b1; IrqClr = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        tick();
        check_all_zero("rst");

        // One-shot, N=3: decrements at edges 5, 9, 13; Done after edge 13 only
        load_preset(W'(3));
        start_pulse();
        check("os_busy0", W'(Busy), W'(1));
        for (int e = 1; e <= 13; e++) begin
            tick();
            check("os_done", W'(Done), W'(e == 13));
            if (e == 5) check("os_cnt5", Count, W'(2));
            if (e == 9) check("os_cnt9", Count, W'(1));
        end
        check("os_cnt_exp", Count, W'(0));
        tick();
        check("os_done_end", W'(Done), W'(0));
        check("os_busy_end", W'(Busy), W'(0));
        check("os_cnt_end",  Count,    W'(0));
        check("os_irq_end",  W'(Irq),  W'(1));
        tick();
        check("os_cnt_hold", Count, W'(0));
        IrqClr = 1'b1;
        tick();
        IrqClr = 1'b0;
        check("irqclr", W'(Irq), W'(0));

        // Auto-reload, period 14: Done after 13, 27, 41; IrqClr through the second expiry
        Mode = 1'b1;
        start_pulse();
        for (int e = 1; e <= 42; e++) begin
            IrqClr = (e == 27 || e == 28);
            tick();
            check("ar_done", W'(Done), W'(e == 13 || e == 27 || e == 41));
            if (e == 28) check("ar_irq_set_wins", W'(Irq), W'(1));
        end
        IrqClr = 1'b0;
        check("ar_busy", W'(Busy), W'(1));
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        Mode = 1'b0;
        check("ar_stop_busy", W'(Busy), W'(0));
        IrqClr = 1'b1;
        tick();
        IrqClr = 1'b0;

        // En low on edges 7..11 delays expiry from edge 13 to 18
        start_pulse();
        for (int e = 1; e <= 19; e++) begin
            En = !(e >= 7 && e <= 11);
            tick();
            check("en_done", W'(Done), W'(e == 18));
            if (e == 11) check("en_cnt_frozen", Count, W'(2));
            if (e == 14) check("en_cnt14", Count, W'(1));
        end
        En = 1'b1;
        check("en_irq", W'(Irq), W'(1));

        // Start while busy is ignored; Stop at Count=2 returns to IDLE holding Count
        start_pulse();
        for (int e = 1; e <= 5; e++) begin
            Start = (e == 2 || e == 3);
            tick();
        end
        Start = 1'b0;
        check("stop_pre_cnt", Count, W'(2));
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        check("stop_busy", W'(Busy), W'(0));
        check("stop_cnt",  Count,    W'(2));
        check("stop_done", W'(Done), W'(0));
        tick();
        tick();
        check("stop_cnt_hold", Count, W'(2));

        // Preset 0: LOAD then straight to EXPIRE
        load_preset(W'(0));
        start_pulse();
        check("z_done0", W'(Done), W'(0));
        tick();
        check("z_done1", W'(Done), W'(1));
        check("z_cnt1",  Count,    W'(0));
        tick();
        check("z_done2", W'(Done), W'(0));
        check("z_busy2", W'(Busy), W'(0));

        // Reset during COUNT
        load_preset(W'(3));
        start_pulse();
        for (int e = 1; e <= 6; e++) tick();
        check("rc_busy_pre", W'(Busy), W'(1));
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_all_zero("rst_count");

        // Reset during EXPIRE (Preset was cleared by reset, so reload it)
        load_preset(W'(1));
        start_pulse();
        for (int e = 1; e <= 5; e++) tick();
        check("re_done_pre", W'(Done), W'(1));
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_all_zero("rst_expire");

        // Load 7 mid-COUNT in auto-reload: second period is 7*4 long, Done after 13 and 43
        load_preset(W'(3));
        Mode = 1'b1;
        start_pulse();
        for (int e = 1; e <= 44; e++) begin
            Load    = (e == 3);
            LoadVal = W'(7);
            tick();
            check("rl_done", W'(Done), W'(e == 13 || e == 43));
            if (e == 5)  check("rl_cnt_old", Count, W'(2));
            if (e == 15) check("rl_cnt_new", Count, W'(7));
        end
        Load = 1'b0;
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        check("rl_stop_busy", W'(Busy), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
